// File: rtl/frame_pkg.sv
// Shared definitions for the frame source scheduler.
//  - Default frame geometry (payload bytes, marker length, guard gap).
//  - FSM state encoding.
//  - cnt_width(): width of a counter that must hold values 0..max(a,b)-1.
package frame_pkg;

  localparam int BYTES_IN_FRAME_DEFAULT = 32;
  localparam int MARKER_BITS            = 32;
  // Guard gap covers the marker the framer inserts plus its one-cycle latency.
  localparam int GAP_CYCLES_DEFAULT     = MARKER_BITS + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter (purely combinational).
// Ports:
//   req  in  2  request vector, bit n = source n
//   last in  1  source served most recently
//   gnt  out 2  one-hot-or-zero grant
// With both sources requesting, the source that was not served last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/frame_src_scheduler.sv
// Schedules two serial bit sources onto a single marker framer, one whole
// payload frame at a time, then holds a guard gap until the framer drains.
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   REQ0, REQ1        source has a full frame ready (sampled in IDLE only)
//   IN0, IN1          serial source data, one bit per granted cycle
//   FR_VALID_OUT      framer still emitting
//   GNT0, GNT1        registered grants (one-hot-or-zero)
//   FR_IN             granted source bit to framer (combinational mux)
//   FR_VALID_IN       GNT0 | GNT1
//   SRC_ID            source of current/last frame
//   FRAME_DONE        pulse on the last payload bit
//   BUSY              high in GRANT and GAP
module frame_src_scheduler
  import frame_pkg::*;
#(
  parameter int BYTES_IN_FRAME = BYTES_IN_FRAME_DEFAULT,
  parameter int GAP_CYCLES     = GAP_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ0,
  input  logic REQ1,
  input  logic IN0,
  input  logic IN1,
  input  logic FR_VALID_OUT,
  output logic GNT0,
  output logic GNT1,
  output logic FR_IN,
  output logic FR_VALID_IN,
  output logic SRC_ID,
  output logic FRAME_DONE,
  output logic BUSY
);

  localparam int FRAME_BITS = 8 * BYTES_IN_FRAME;
  localparam int CW         = cnt_width(FRAME_BITS, GAP_CYCLES);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
  // FRAME_DONE is registered, so it is set one count ahead of the last bit.
  localparam logic [CW-1:0] DONE_AT  = CW'(FRAME_BITS - 2);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            gnt0_reg, gnt0_next;
  logic            gnt1_reg, gnt1_next;
  logic            src_reg, src_next;
  logic            last_reg, last_next;
  logic            done_reg, done_next;
  logic            busy_reg, busy_next;
  logic [1:0]      arb_gnt;

  rr_arb2 u_arb (
    .req  ({REQ1, REQ0}),
    .last (last_reg),
    .gnt  (arb_gnt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      gnt0_reg  <= 1'b0;
      gnt1_reg  <= 1'b0;
      src_reg   <= 1'b0;
      // "Last served = 1" makes source 0 win the first contested arbitration.
      last_reg  <= 1'b1;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      gnt0_reg  <= gnt0_next;
      gnt1_reg  <= gnt1_next;
      src_reg   <= src_next;
      last_reg  <= last_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    gnt0_next  = gnt0_reg;
    gnt1_next  = gnt1_reg;
    src_next   = src_reg;
    last_next  = last_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|arb_gnt) begin
          state_next = ST_GRANT;
          cnt_next   = '0;
          gnt0_next  = arb_gnt[0];
          gnt1_next  = arb_gnt[1];
          src_next   = arb_gnt[1];
        end
      end
      ST_GRANT: begin
        // REQ is deliberately not looked at here: a started frame always completes.
        if (cnt_reg == LAST_BIT) begin
          state_next = ST_GAP;
          cnt_next   = '0;
          gnt0_next  = 1'b0;
          gnt1_next  = 1'b0;
          last_next  = src_reg;
        end else begin
          cnt_next  = cnt_reg + 1'b1;
          done_next = (cnt_reg == DONE_AT);
        end
      end
      ST_GAP: begin
        // Counter saturates; exit also waits for the framer to go quiet.
        if (cnt_reg == GAP_LAST) begin
          if (!FR_VALID_OUT) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
        gnt0_next  = 1'b0;
        gnt1_next  = 1'b0;
      end
    endcase
    busy_next = (state_next != ST_IDLE);
  end

  assign GNT0        = gnt0_reg;
  assign GNT1        = gnt1_reg;
  assign FR_VALID_IN = gnt0_reg | gnt1_reg;
  assign FR_IN       = (gnt0_reg & IN0) | (gnt1_reg & IN1);
  assign SRC_ID      = src_reg;
  assign FRAME_DONE  = done_reg;
  assign BUSY        = busy_reg;

endmodule
